// File: rtl/apb_slv_adapter_pkg.sv
// Shared types and sizing helper for the APB-to-native register adapter.
package apb_slv_adapter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } adp_state_t;

  // A zero timeout still needs a 1-bit counter so the port list stays legal.
  function automatic int unsigned adp_cnt_w(input int unsigned timeout_cyc);
    return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/acc_timeout_cnt.sv
// Access watchdog: counts enabled cycles since clr, saturating, and flags (combinationally) the
// counting cycle that reaches TIMEOUT_CYC; no backpressure, TIMEOUT_CYC = 0 never expires.
module acc_timeout_cnt
  import apb_slv_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW       = adp_cnt_w(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry is the cycle whose increment would land on TIMEOUT_CYC.
  assign w_at_last = (r_cnt == CNT_LAST);
  assign expired   = (TIMEOUT_CYC != 0) && en && w_at_last;

endmodule

// File: rtl/apb_slv_adapter.sv
// APB4 completer onto the native req/ack register interface, one access in flight; setup to pready
// is 4 cycles minimum, pready waits for ack or a watchdog abort, a psel drop aborts the access.
module apb_slv_adapter
  import apb_slv_adapter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    soft_rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic                    if_soft_rst,
  output logic                    if_req_vld,
  output logic                    if_wr_en,
  output logic                    if_rd_en,
  output logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_wr_data,
  output logic [DATA_WIDTH/8-1:0] if_wr_strb,
  input  logic                    if_ack_vld,
  input  logic [DATA_WIDTH-1:0]   if_rd_data,
  input  logic                    if_err
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  adp_state_t            r_state;
  adp_state_t            w_state_nxt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_strb;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pslverr;
  logic                  r_abort;

  logic w_capture;
  logic w_ack_take;
  logic w_timeout;
  logic w_mabort;
  logic w_expired;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_in_flight;

  // The watchdog only advances while the access is genuinely waiting on the slave.
  assign w_wd_clr = soft_rst || (r_state == S_REQ);
  assign w_wd_en  = (r_state == S_WAIT) && psel && !if_ack_vld && !soft_rst;

  acc_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_ack_take  = 1'b0;
    w_timeout   = 1'b0;
    w_mabort    = 1'b0;
    if (soft_rst) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          // psel & penable here is an access phase without a setup phase: ignored.
          if (psel && !penable) begin
            w_capture   = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
        S_REQ: begin
          if (!psel) begin
            w_mabort    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          // Ack beats a coincident expiry; a departed master beats both.
          if (!psel) begin
            w_mabort    = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (if_ack_vld) begin
            w_ack_take  = 1'b1;
            w_state_nxt = S_RESP;
          end else if (w_expired) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
        S_RESP: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (soft_rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_capture) begin
      r_write <= pwrite;
      r_addr  <= paddr;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      r_abort   <= 1'b0;
    end else if (soft_rst) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_abort <= w_timeout || w_mabort;
      if (w_ack_take) begin
        r_prdata  <= r_write ? '0 : if_rd_data;
        r_pslverr <= if_err;
      end else if (w_timeout) begin
        r_prdata  <= '0;
        r_pslverr <= 1'b1;
      end else if (r_state == S_RESP) begin
        r_prdata  <= '0;
        r_pslverr <= 1'b0;
      end
    end
  end

  assign w_in_flight = (r_state == S_REQ) || (r_state == S_WAIT);

  assign pready      = (r_state == S_RESP);
  assign prdata      = r_prdata;
  assign pslverr     = r_pslverr;
  assign if_soft_rst = soft_rst || r_abort;
  assign if_req_vld  = (r_state == S_REQ);
  assign if_wr_en    = w_in_flight && r_write;
  assign if_rd_en    = w_in_flight && !r_write;
  assign if_addr     = r_addr;
  assign if_wr_data  = r_wdata;
  assign if_wr_strb  = r_strb;

endmodule

// File: tb/tb_apb_slv_adapter.sv
// Bench for apb_slv_adapter: dut_a uses the default watchdog, dut_b a 4-cycle watchdog.
module tb_apb_slv_adapter;

  localparam int TO_B = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          srst;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, soft_rst, psel, penable, pwrite, if_ack_vld, if_err, sel;
  logic [31:0] paddr, pwdata, if_rd_data;
  logic [3:0]  pstrb;
  logic        psel_a, psel_b;

  logic        pready_a, pslverr_a, srst_a, req_a, wr_a, rd_a;
  logic        pready_b, pslverr_b, srst_b, req_b, wr_b, rd_b;
  logic [31:0] prdata_a, addr_a, wdat_a, prdata_b, addr_b, wdat_b;
  logic [3:0]  strb_a, strb_b;

  logic        pready, pslverr, if_soft_rst, if_req_vld, if_wr_en, if_rd_en;
  logic [31:0] prdata, if_addr, if_wr_data;
  logic [3:0]  if_wr_strb;
  logic [105:0] outs_a, outs_b, outs;

  assign psel_a = psel && !sel;
  assign psel_b = psel && sel;
  assign outs_a = {pready_a, prdata_a, pslverr_a, srst_a, req_a, wr_a, rd_a, addr_a, wdat_a, strb_a};
  assign outs_b = {pready_b, prdata_b, pslverr_b, srst_b, req_b, wr_b, rd_b, addr_b, wdat_b, strb_b};
  assign outs   = sel ? outs_b : outs_a;
  assign {pready, prdata, pslverr, if_soft_rst, if_req_vld, if_wr_en, if_rd_en,
          if_addr, if_wr_data, if_wr_strb} = outs;

  apb_slv_adapter dut_a (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
    .psel(psel_a), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a), .if_soft_rst(srst_a),
    .if_req_vld(req_a), .if_wr_en(wr_a), .if_rd_en(rd_a), .if_addr(addr_a),
    .if_wr_data(wdat_a), .if_wr_strb(strb_a),
    .if_ack_vld(if_ack_vld), .if_rd_data(if_rd_data), .if_err(if_err)
  );

  apb_slv_adapter #(.TIMEOUT_CYC(TO_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
    .psel(psel_b), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b), .if_soft_rst(srst_b),
    .if_req_vld(req_b), .if_wr_en(wr_b), .if_rd_en(rd_b), .if_addr(addr_b),
    .if_wr_data(wdat_b), .if_wr_strb(strb_b),
    .if_ack_vld(if_ack_vld), .if_rd_data(if_rd_data), .if_err(if_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  // Observations recorded by the driver for the tests to judge.
  logic        o_rdy, o_err, o_req_wr, o_req_rd, o_post_err, o_post_srst, o_post_wr, o_post_rd;
  logic [31:0] o_data, o_req_addr, o_req_data, o_post_data, o_post_addr;
  logic [3:0]  o_req_strb;
  int          o_cyc, o_req_cnt, o_srst_cnt;

  // One APB transfer; cycle 0 = setup, slave acks in WAIT cycle ack_at (-1 never), psel drops at drop_at.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int ack_at, input logic [31:0] rdat, input logic err, input int drop_at);
    int cyc;
    int lim;
    o_rdy = 1'b0; o_data = 'x; o_err = 1'bx; o_cyc = -1; o_req_cnt = 0; o_srst_cnt = 0;
    o_req_wr = 1'b0; o_req_rd = 1'b0; o_req_addr = '0; o_req_data = '0; o_req_strb = '0;
    lim = (drop_at >= 0) ? 8 : 40;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    if_rd_data = rdat; if_err = err;
    cyc = 0;
    @(negedge clk);
    penable = 1'b1;
    cyc = 1;
    while (!o_rdy && cyc < lim) begin
      if (if_req_vld) begin
        o_req_cnt++;
        o_req_wr = if_wr_en; o_req_rd = if_rd_en; o_req_addr = if_addr;
        o_req_data = if_wr_data; o_req_strb = if_wr_strb;
      end
      if (if_soft_rst) o_srst_cnt++;
      if (pready) begin
        o_rdy = 1'b1; o_data = prdata; o_err = pslverr; o_cyc = cyc;
      end
      if (cyc == drop_at) begin
        psel = 1'b0; penable = 1'b0;
      end
      if_ack_vld = (ack_at >= 0) && (cyc == ack_at + 2);
      @(negedge clk);
      cyc++;
    end
    if_ack_vld = 1'b0; psel = 1'b0; penable = 1'b0;
    #1;
    o_post_data = prdata; o_post_err = pslverr; o_post_srst = if_soft_rst;
    o_post_wr = if_wr_en; o_post_rd = if_rd_en; o_post_addr = if_addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; soft_rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; if_ack_vld = 1'b0; if_rd_data = '0; if_err = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (outs_a !== '0) begin n_err++; $display("FAIL reset_a: outputs=%h want 0", outs_a); end
    n_cmp++;
    if (outs_b !== '0) begin n_err++; $display("FAIL reset_b: outputs=%h want 0", outs_b); end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    exp_t e;
    sel = 1'b0;
    sb.push_back('{32'h0, 1'b0, 3, 0});
    xfer(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 1'b0, -1);
    e = sb.pop_front();
    n_cmp++;
    if ({o_rdy, o_data, o_err, o_cyc, o_srst_cnt} !== {1'b1, e.data, e.err, e.cyc, e.srst}) begin
      n_err++;
      $display("FAIL write_resp: rdy=%b data=%h err=%b cyc=%0d srst=%0d want 1 %h %b %0d %0d",
               o_rdy, o_data, o_err, o_cyc, o_srst_cnt, e.data, e.err, e.cyc, e.srst);
    end
    n_cmp++;
    if ({o_req_cnt, o_req_wr, o_req_rd, o_req_addr, o_req_data, o_req_strb} !==
        {32'd1, 1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, 4'hF}) begin
      n_err++;
      $display("FAIL write_req: cnt=%0d wr=%b rd=%b addr=%h data=%h strb=%h want 1 1 0 1000 deadbeef f",
               o_req_cnt, o_req_wr, o_req_rd, o_req_addr, o_req_data, o_req_strb);
    end
    n_cmp++;
    if ({o_post_data, o_post_err, o_post_wr, o_post_addr} !== {32'h0, 1'b0, 1'b0, 32'h1000}) begin
      n_err++;
      $display("FAIL write_after: prdata=%h pslverr=%b wr_en=%b addr=%h want 0 0 0 1000",
               o_post_data, o_post_err, o_post_wr, o_post_addr);
    end
  endtask

  task automatic test_read();
    logic [31:0] addr_t[2] = '{32'h2004, 32'h3008};
    int          ack_t [2] = '{5, 1};
    logic [31:0] rdat_t[2] = '{32'h12345678, 32'hCAFEF00D};
    logic        err_t [2] = '{1'b0, 1'b1};
    exp_t e;
    sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{rdat_t[i], err_t[i], ack_t[i] + 3, 0});
      xfer(1'b0, addr_t[i], 32'h0, 4'h0, ack_t[i], rdat_t[i], err_t[i], -1);
      e = sb.pop_front();
      n_cmp++;
      if ({o_rdy, o_data, o_err, o_cyc} !== {1'b1, e.data, e.err, e.cyc}) begin
        n_err++;
        $display("FAIL read%0d_resp: rdy=%b data=%h err=%b cyc=%0d want 1 %h %b %0d",
                 i, o_rdy, o_data, o_err, o_cyc, e.data, e.err, e.cyc);
      end
      n_cmp++;
      if ({o_req_cnt, o_req_wr, o_req_rd, o_req_addr} !== {32'd1, 1'b0, 1'b1, addr_t[i]}) begin
        n_err++;
        $display("FAIL read%0d_req: cnt=%0d wr=%b rd=%b addr=%h want 1 0 1 %h",
                 i, o_req_cnt, o_req_wr, o_req_rd, o_req_addr, addr_t[i]);
      end
    end
  endtask

  task automatic test_protocol_err();
    int seen;
    sel = 1'b0;
    seen = 0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; paddr = 32'hBAD0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_req_vld || pready || if_rd_en || if_wr_en) seen++;
    end
    psel = 1'b0; penable = 1'b0;
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL protocol_err: active cycles=%0d want 0", seen); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic        wr, err;
    logic [31:0] a, d, r;
    int          ack;
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr  = 1'($urandom_range(0, 1));
      err = 1'($urandom_range(0, 1));
      a   = $urandom & 32'hFFFF_FFFC;
      d   = $urandom;
      r   = $urandom;
      ack = $urandom_range(0, 3);
      sb.push_back('{(wr ? 32'h0 : r), err, ack + 3, 0});
      xfer(wr, a, d, 4'hF, ack, r, err, -1);
      e = sb.pop_front();
      n_cmp++;
      if ({o_rdy, o_data, o_err, o_cyc, o_srst_cnt} !== {1'b1, e.data, e.err, e.cyc, e.srst}) begin
        n_err++;
        $display("FAIL b2b%0d_resp: rdy=%b data=%h err=%b cyc=%0d srst=%0d want 1 %h %b %0d %0d",
                 i, o_rdy, o_data, o_err, o_cyc, o_srst_cnt, e.data, e.err, e.cyc, e.srst);
      end
      n_cmp++;
      if ({o_req_wr, o_req_rd, o_req_addr, o_req_data} !== {wr, !wr, a, d}) begin
        n_err++;
        $display("FAIL b2b%0d_req: wr=%b rd=%b addr=%h data=%h want %b %b %h %h",
                 i, o_req_wr, o_req_rd, o_req_addr, o_req_data, wr, !wr, a, d);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sel = 1'b1;
    sb.push_back('{32'h0, 1'b1, 2 + TO_B, 1});
    xfer(1'b0, 32'h40, 32'h0, 4'hF, -1, 32'hFFFF_FFFF, 1'b0, -1);
    e = sb.pop_front();
    n_cmp++;
    if ({o_rdy, o_data, o_err, o_cyc, o_srst_cnt} !== {1'b1, e.data, e.err, e.cyc, e.srst}) begin
      n_err++;
      $display("FAIL timeout_resp: rdy=%b data=%h err=%b cyc=%0d srst=%0d want 1 %h %b %0d %0d",
               o_rdy, o_data, o_err, o_cyc, o_srst_cnt, e.data, e.err, e.cyc, e.srst);
    end
    n_cmp++;
    if ({o_post_srst, o_post_data, o_post_err} !== {1'b0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_after: srst=%b prdata=%h pslverr=%b want 0 0 0",
               o_post_srst, o_post_data, o_post_err);
    end
    sb.push_back('{32'h0, 1'b0, 3, 0});
    xfer(1'b1, 32'h44, 32'h0BADCAFE, 4'h3, 0, 32'h1111_2222, 1'b0, -1);
    e = sb.pop_front();
    n_cmp++;
    if ({o_rdy, o_data, o_err, o_cyc, o_srst_cnt} !== {1'b1, e.data, e.err, e.cyc, e.srst}) begin
      n_err++;
      $display("FAIL timeout_recover: rdy=%b data=%h err=%b cyc=%0d srst=%0d want 1 %h %b %0d %0d",
               o_rdy, o_data, o_err, o_cyc, o_srst_cnt, e.data, e.err, e.cyc, e.srst);
    end
    n_cmp++;
    if ({o_req_wr, o_req_addr, o_req_data, o_req_strb} !== {1'b1, 32'h44, 32'h0BADCAFE, 4'h3}) begin
      n_err++;
      $display("FAIL timeout_recover_req: wr=%b addr=%h data=%h strb=%h want 1 44 0badcafe 3",
               o_req_wr, o_req_addr, o_req_data, o_req_strb);
    end
  endtask

  task automatic test_ack_vs_expiry();
    exp_t e;
    sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{32'h5A5A0001 + i, 1'(i), 2 + TO_B, 0});
      xfer(1'b0, 32'h50, 32'h0, 4'hF, TO_B - 1, 32'h5A5A0001 + i, 1'(i), -1);
      e = sb.pop_front();
      n_cmp++;
      if ({o_rdy, o_data, o_err, o_cyc, o_srst_cnt} !== {1'b1, e.data, e.err, e.cyc, e.srst}) begin
        n_err++;
        $display("FAIL ack_vs_expiry%0d: rdy=%b data=%h err=%b cyc=%0d srst=%0d want 1 %h %b %0d %0d",
                 i, o_rdy, o_data, o_err, o_cyc, o_srst_cnt, e.data, e.err, e.cyc, e.srst);
      end
    end
  endtask

  task automatic test_master_abort();
    exp_t e;
    sel = 1'b0;
    for (int drop = 1; drop <= 2; drop++) begin
      xfer(1'b1, 32'h60, 32'h77, 4'hF, -1, 32'h0, 1'b0, drop);
      n_cmp++;
      if ({o_rdy, o_srst_cnt, o_req_cnt, o_post_wr, o_post_rd} !== {1'b0, 32'd1, 32'd1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL mabort_drop%0d: rdy=%b srst=%0d req=%0d wr_en=%b rd_en=%b want 0 1 1 0 0",
                 drop, o_rdy, o_srst_cnt, o_req_cnt, o_post_wr, o_post_rd);
      end
    end
    sb.push_back('{32'h600D600D, 1'b0, 4, 0});
    xfer(1'b0, 32'h64, 32'h0, 4'h0, 1, 32'h600D600D, 1'b0, -1);
    e = sb.pop_front();
    n_cmp++;
    if ({o_rdy, o_data, o_err, o_cyc, o_srst_cnt} !== {1'b1, e.data, e.err, e.cyc, e.srst}) begin
      n_err++;
      $display("FAIL mabort_recover: rdy=%b data=%h err=%b cyc=%0d srst=%0d want 1 %h %b %0d %0d",
               o_rdy, o_data, o_err, o_cyc, o_srst_cnt, e.data, e.err, e.cyc, e.srst);
    end
  endtask

  task automatic test_soft_rst();
    sel = 1'b0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h7770; pwdata = 32'h1234; pstrb = 4'h5;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({if_rd_en, if_addr} !== {1'b1, 32'h7770}) begin
      n_err++;
      $display("FAIL soft_rst_wait: rd_en=%b addr=%h want 1 7770", if_rd_en, if_addr);
    end
    soft_rst = 1'b1;
    #1;
    n_cmp++;
    if (if_soft_rst !== 1'b1) begin
      n_err++; $display("FAIL soft_rst_out: if_soft_rst=%b want 1", if_soft_rst);
    end
    @(negedge clk);
    soft_rst = 1'b0;
    #1;
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL soft_rst_idle: outputs=%h want 0", outs); end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_hard_rst();
    exp_t e;
    sel = 1'b0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8880; pwdata = 32'h5678; pstrb = 4'hA;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL hard_rst: outputs=%h want 0", outs); end
    @(negedge clk);
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    sb.push_back('{32'h0, 1'b1, 5, 0});
    xfer(1'b1, 32'h8884, 32'h9, 4'h1, 2, 32'h0, 1'b1, -1);
    e = sb.pop_front();
    n_cmp++;
    if ({o_rdy, o_data, o_err, o_cyc, o_srst_cnt} !== {1'b1, e.data, e.err, e.cyc, e.srst}) begin
      n_err++;
      $display("FAIL hard_rst_recover: rdy=%b data=%h err=%b cyc=%0d srst=%0d want 1 %h %b %0d %0d",
               o_rdy, o_data, o_err, o_cyc, o_srst_cnt, e.data, e.err, e.cyc, e.srst);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_protocol_err();
    test_back_to_back();
    test_timeout();
    test_ack_vs_expiry();
    test_master_abort();
    test_soft_rst();
    test_hard_rst();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
